timer_ctrl: RTL
===============

Name: timer_ctrl

Overview:
Programmable interval controller that sequences an internal width-bit up-counter: loads a period through a valid/ready config handshake, then runs, pauses, stops and restarts the count. It emits a one-cycle tick at each period boundary, in one-shot or periodic mode. It is the scheduling front-end for counter-based timing in the design, and exposes the live count for downstream logic.

Parameters:
width, 8, bit width of the counter, period register and tick counter (>=2)

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous, active-low reset
cfg_valid  in  1  config request
cfg_ready  out  1  config accepted when cfg_valid & cfg_ready
cfg_period  in  width  period in cycles; 0 is illegal
cfg_periodic  in  1  1 = periodic, 0 = one-shot
start  in  1  level-sampled start request
pause  in  1  level: hold the count while high
stop  in  1  abort to IDLE, clear count
cnt  out  width  current count
tick  out  1  one-cycle pulse at period end
tick_cnt  out  width  ticks since last start, wraps mod 2^width
busy  out  1  state is RUN or PAUSE
done  out  1  state is DONE (one-shot finished)

Behaviour:
- States: IDLE, RUN, PAUSE, DONE. All outputs are registered.
- Reset (rst=0, asynchronous): state=IDLE, cnt=0, tick=0, tick_cnt=0, period_reg=0, periodic_reg=0, busy=0, done=0.
- cfg_ready=1 only in IDLE or DONE.
- On a config handshake: period_reg<=cfg_period and periodic_reg<=cfg_periodic at the edge. The state does not change.
- IDLE/DONE + start=1 + period_reg!=0 -> RUN. At the same edge: cnt<=0, tick_cnt<=0, done<=0.
- start with period_reg==0 is ignored (stay in state).
- A config handshake and start in the same cycle: the newly loaded period is used (config has priority over start). If cfg_period==0 in that cycle, start is ignored.
- RUN, normal cycle: cnt<=cnt+1 each cycle, modulo 2^width.
- RUN, terminal cycle (cnt==period_reg-1):
  - cnt<=0, tick<=1 for exactly one cycle, tick_cnt<=tick_cnt+1.
  - periodic_reg=1: stay in RUN. Tick spacing is exactly period_reg cycles.
  - periodic_reg=0: -> DONE, done<=1, busy<=0.
- period_reg==1: the terminal condition holds every cycle. Periodic mode gives tick continuously high; one-shot gives a single tick.
- RUN + pause=1 -> PAUSE. cnt is frozen from the next edge; the terminal check is not evaluated in PAUSE.
- PAUSE + pause=0 -> RUN. Counting resumes from the frozen value.
- Pause and terminal in the same cycle: the terminal update wins (tick, cnt<=0, DONE if one-shot). The next state is PAUSE only if periodic.
- stop=1 in any state -> IDLE at the next edge. cnt<=0, busy<=0, done<=0, tick<=0. tick_cnt holds.
- stop has the highest priority, above start, pause, terminal and config.
- start while in RUN or PAUSE is ignored (no restart).
- Config writes are impossible while busy (cfg_ready=0). A running period cannot change mid-operation.
- An asynchronous reset mid-run aborts immediately to the reset values. No tick is issued.
- tick is 0 in every cycle other than the one following a terminal edge.

Test Plan:
- Reset then idle: hold rst=0, release, 10 idle cycles -> cnt=0, tick=0, busy=0, done=0, cfg_ready=1 throughout.
- Periodic, period 4: config 4/periodic, start for 1 cycle -> cnt sequence 0,1,2,3,0,1,...; tick high exactly when cnt returns to 0, every 4 cycles; after 3 ticks tick_cnt=3, busy=1, cfg_ready=0.
- One-shot, period 5: start -> one tick 5 cycles after RUN entry, then done=1, busy=0, cnt=0, cfg_ready=1; start again -> done=0 and a second tick 5 cycles later.
- Pause: period 6, pause=1 at cnt=2 for 3 cycles -> cnt holds 3 for 3 cycles, no tick; the tick arrives 3 cycles later than it would without the pause; pause asserted at cnt=5 -> the tick still fires and cnt=0 is held.
- Priority: stop and start together in DONE -> IDLE; stop at cnt=3 of period 4 -> no tick, cnt=0, tick_cnt unchanged; start with period_reg=0 -> stays IDLE.
- Edge cases: period 1 periodic -> tick continuously 1, tick_cnt increments each cycle; period 255 with width 8 runs cnt 0..254 then wraps to 0; rst pulsed low mid-run -> all outputs at reset values immediately.

Source files
------------

// File: rtl/timer_ctrl_if.sv
// Config handshake bundle for timer_ctrl.
// The master offers a period/mode; the slave accepts it when ready.
interface timer_ctrl_if #(
    parameter int width = 8
) ();
    logic             cfg_valid;
    logic             cfg_ready;
    logic [width-1:0] cfg_period;
    logic             cfg_periodic;

    modport master (
        output cfg_valid,
        output cfg_period,
        output cfg_periodic,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_period,
        input  cfg_periodic,
        output cfg_ready
    );
endinterface

// File: rtl/timer_ctrl.sv
// Programmable interval controller: configurable period up-counter
// with run/pause/stop control and one-shot or periodic tick output.
module timer_ctrl #(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             rst,
    timer_ctrl_if.slave      cfg,
    input  logic             start,
    input  logic             pause,
    input  logic             stop,
    output logic [width-1:0] cnt,
    output logic             tick,
    output logic [width-1:0] tick_cnt,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE,
        S_DONE
    } state_t;

    localparam logic [width-1:0] ONE  = {{(width-1){1'b0}}, 1'b1};
    localparam logic [width-1:0] ZERO = '0;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [width-1:0] r_cnt;
    logic [width-1:0] w_cnt_nxt;
    logic [width-1:0] r_tick_cnt;
    logic [width-1:0] w_tick_cnt_nxt;
    logic [width-1:0] r_period;
    logic [width-1:0] w_period_nxt;
    logic             r_periodic;
    logic             w_periodic_nxt;
    logic             r_tick;
    logic             w_tick_nxt;
    logic             r_busy;
    logic             r_done;
    logic             r_cfg_ready;
    logic             w_hs;
    logic             w_term;
    logic [width-1:0] w_per_eff;

    assign w_hs      = cfg.cfg_valid & r_cfg_ready;
    // A period loaded in the same cycle as start is the one used.
    assign w_per_eff = w_hs ? cfg.cfg_period : r_period;
    assign w_term    = (r_cnt == (r_period - ONE));

    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_tick_cnt_nxt = r_tick_cnt;
        w_period_nxt   = r_period;
        w_periodic_nxt = r_periodic;
        w_tick_nxt     = 1'b0;
        if (stop) begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = ZERO;
        end else begin
            unique case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_hs) begin
                        w_period_nxt   = cfg.cfg_period;
                        w_periodic_nxt = cfg.cfg_periodic;
                    end
                    if (start && (w_per_eff != ZERO)) begin
                        w_state_nxt    = S_RUN;
                        w_cnt_nxt      = ZERO;
                        w_tick_cnt_nxt = ZERO;
                    end
                end
                S_RUN: begin
                    if (w_term) begin
                        w_cnt_nxt      = ZERO;
                        w_tick_nxt     = 1'b1;
                        w_tick_cnt_nxt = r_tick_cnt + ONE;
                        if (!r_periodic) begin
                            w_state_nxt = S_DONE;
                        end else if (pause) begin
                            w_state_nxt = S_PAUSE;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + ONE;
                        if (pause) begin
                            w_state_nxt = S_PAUSE;
                        end
                    end
                end
                S_PAUSE: begin
                    if (!pause) begin
                        w_state_nxt = S_RUN;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= ZERO;
            r_tick_cnt  <= ZERO;
            r_period    <= ZERO;
            r_periodic  <= 1'b0;
            r_tick      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_cfg_ready <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_tick_cnt  <= w_tick_cnt_nxt;
            r_period    <= w_period_nxt;
            r_periodic  <= w_periodic_nxt;
            r_tick      <= w_tick_nxt;
            r_busy      <= (w_state_nxt == S_RUN) ||
                           (w_state_nxt == S_PAUSE);
            r_done      <= (w_state_nxt == S_DONE);
            r_cfg_ready <= (w_state_nxt == S_IDLE) ||
                           (w_state_nxt == S_DONE);
        end
    end

    assign cnt           = r_cnt;
    assign tick          = r_tick;
    assign tick_cnt      = r_tick_cnt;
    assign busy          = r_busy;
    assign done          = r_done;
    assign cfg.cfg_ready = r_cfg_ready;

endmodule
